// File: rtl/ddr_resp_pkg.sv
// rtl/ddr_resp_pkg.sv - shared widths, FSM state type and latency counter width for ddr_responder.
package ddr_resp_pkg;

  localparam int LINE_W         = 512;
  localparam int WORD_W         = 64;
  localparam int WORDS_PER_LINE = 8;
  localparam int OFFSET_BITS    = 6;
  localparam int WORD_IDX_W     = $clog2(WORDS_PER_LINE);
  localparam int CNT_W          = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } ddr_state_t;

  // Bit position of the low bit of a 64-bit word lane within a line.
  function automatic logic [8:0] word_lsb(input logic [WORD_IDX_W-1:0] w);
    return {w, 6'b0};
  endfunction

endpackage

// File: rtl/ddr_resp_mem.sv
// rtl/ddr_resp_mem.sv - single-port 512-bit line array with masked write and word/burst lane select.
module ddr_resp_mem
  import ddr_resp_pkg::*;
#(
  parameter int LINE_AW = 10
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  i_en,
  input  logic                  i_we,
  input  logic                  i_burst,
  input  logic [LINE_AW-1:0]    i_line,
  input  logic [WORD_IDX_W-1:0] i_word,
  input  logic [LINE_W-1:0]     i_mask,
  input  logic [LINE_W-1:0]     i_data,
  output logic [LINE_W-1:0]     o_rdata
);

  logic [LINE_W-1:0] r_mem [2**LINE_AW];
  logic [LINE_W-1:0] r_rdata;
  logic [LINE_W-1:0] w_bmask;
  logic [LINE_W-1:0] w_bdata;
  logic [WORD_W-1:0] w_rword;

  // Word accesses steer the low 64 mask/data bits into the addressed lane.
  always_comb begin
    w_bmask = i_mask;
    w_bdata = i_data;
    if (!i_burst) begin
      w_bmask = LINE_W'(i_mask[WORD_W-1:0]) << word_lsb(i_word);
      w_bdata = LINE_W'(i_data[WORD_W-1:0]) << word_lsb(i_word);
    end
  end

  assign w_rword = r_mem[i_line][word_lsb(i_word) +: WORD_W];

  always_ff @(posedge clock) begin
    if (i_en && i_we) begin
      r_mem[i_line] <= (r_mem[i_line] & ~w_bmask) | (w_bdata & w_bmask);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_rdata <= '0;
    end else if (i_en && !i_we) begin
      r_rdata <= i_burst ? r_mem[i_line] : LINE_W'(w_rword);
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/ddr_responder.sv
// rtl/ddr_responder.sv - DDR channel target: latency FSM in front of a line-organised backing store.
// Defining DDR_RESP_JITTER_EN adds 0..3 LFSR-chosen wait cycles per request.
module ddr_responder
  import ddr_resp_pkg::*;
#(
  parameter int LINE_AW    = 10,
  parameter int RD_LATENCY = 4,
  parameter int WR_LATENCY = 2
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              ddr_chip_enable,
  input  logic [63:0]       ddr_index,
  input  logic              ddr_write_enable,
  input  logic              ddr_burst_mode,
  input  logic [LINE_W-1:0] ddr_write_mask,
  input  logic [LINE_W-1:0] ddr_write_data,
  output logic [LINE_W-1:0] ddr_read_data,
  output logic              ddr_operation_done,
  output logic              ddr_ready
);

`ifdef DDR_RESP_JITTER_EN
  localparam int CW = CNT_W + 1;
`else
  localparam int CW = CNT_W;
`endif

  ddr_state_t              r_state;
  logic [CW-1:0]           r_cnt;
  logic                    r_ready;
  logic                    r_done;
  logic [LINE_AW-1:0]      r_line;
  logic [WORD_IDX_W-1:0]   r_word;
  logic                    r_we;
  logic                    r_burst;
  logic [LINE_W-1:0]       r_mask;
  logic [LINE_W-1:0]       r_data;

  logic                    w_accept;
  logic                    w_commit;
  logic [CW-1:0]           w_base;
  logic [CW-1:0]           w_lat;
  logic [LINE_AW-1:0]      w_idx_line;
  logic [WORD_IDX_W-1:0]   w_idx_word;
  logic [LINE_AW-1:0]      w_m_line;
  logic [WORD_IDX_W-1:0]   w_m_word;
  logic                    w_m_we;
  logic                    w_m_burst;
  logic [LINE_W-1:0]       w_m_mask;
  logic [LINE_W-1:0]       w_m_data;
  logic [LINE_W-1:0]       w_rdata;
  logic                    w_unused_idx;

  assign w_idx_line   = ddr_index[OFFSET_BITS +: LINE_AW];
  assign w_idx_word   = ddr_index[OFFSET_BITS-1 -: WORD_IDX_W];
  assign w_unused_idx = ^{ddr_index[63:OFFSET_BITS+LINE_AW], ddr_index[OFFSET_BITS-WORD_IDX_W-1:0]};

  assign w_accept = (r_state == IDLE) && r_ready && ddr_chip_enable;
  assign w_base   = ddr_write_enable ? CW'(WR_LATENCY - 1) : CW'(RD_LATENCY - 1);

`ifdef DDR_RESP_JITTER_EN
  logic [15:0] r_lfsr;
  logic        w_fb;

  assign w_fb  = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];
  assign w_lat = w_base + CW'(r_lfsr[1:0]);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_lfsr <= 16'hACE1;
    end else begin
      r_lfsr <= {r_lfsr[14:0], w_fb};
    end
  end
`else
  assign w_lat = w_base;
`endif

  // Commit happens on the edge that enters DONE; a zero-wait request commits
  // straight from the port since nothing has been latched yet.
  assign w_commit  = (w_accept && (w_lat == '0)) || ((r_state == WAIT) && (r_cnt == CW'(1)));
  assign w_m_line  = w_accept ? w_idx_line       : r_line;
  assign w_m_word  = w_accept ? w_idx_word       : r_word;
  assign w_m_we    = w_accept ? ddr_write_enable : r_we;
  assign w_m_burst = w_accept ? ddr_burst_mode   : r_burst;
  assign w_m_mask  = w_accept ? ddr_write_mask   : r_mask;
  assign w_m_data  = w_accept ? ddr_write_data   : r_data;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_ready <= 1'b0;
      r_done  <= 1'b0;
      r_line  <= '0;
      r_word  <= '0;
      r_we    <= 1'b0;
      r_burst <= 1'b0;
      r_mask  <= '0;
      r_data  <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          r_ready <= 1'b1;
          if (w_accept) begin
            r_ready <= 1'b0;
            r_line  <= w_idx_line;
            r_word  <= w_idx_word;
            r_we    <= ddr_write_enable;
            r_burst <= ddr_burst_mode;
            r_mask  <= ddr_write_mask;
            r_data  <= ddr_write_data;
            r_cnt   <= w_lat;
            if (w_lat == '0) begin
              r_state <= DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= WAIT;
            end
          end
        end
        WAIT: begin
          r_cnt <= r_cnt - CW'(1);
          if (r_cnt == CW'(1)) begin
            r_state <= DONE;
            r_done  <= 1'b1;
          end
        end
        DONE: begin
          r_state <= IDLE;
          r_ready <= 1'b1;
        end
        default: begin
          r_state <= IDLE;
          r_ready <= 1'b0;
        end
      endcase
    end
  end

  ddr_resp_mem #(
    .LINE_AW (LINE_AW)
  ) u_mem (
    .clock   (clock),
    .reset_n (reset_n),
    .i_en    (w_commit),
    .i_we    (w_m_we),
    .i_burst (w_m_burst),
    .i_line  (w_m_line),
    .i_word  (w_m_word),
    .i_mask  (w_m_mask),
    .i_data  (w_m_data),
    .o_rdata (w_rdata)
  );

  assign ddr_read_data      = w_rdata;
  assign ddr_operation_done = r_done;
  assign ddr_ready          = r_ready;

endmodule

// File: tb/tb_ddr_responder.sv
// tb/tb_ddr_responder.sv - directed self-checking bench for ddr_responder (default and DDR_RESP_JITTER_EN builds).
module tb_ddr_responder;

  localparam int RD_L = 4;
  localparam int WR_L = 2;
  localparam logic [511:0] ONES = {512{1'b1}};
  localparam logic [63:0]  W0   = 64'hDEAD_BEEF_0000_0001;

  logic         clock = 1'b0;
  logic         reset_n = 1'b0;
  logic         ce = 1'b0;
  logic         we = 1'b0;
  logic         burst = 1'b0;
  logic [63:0]  idx = '0;
  logic [511:0] mask = '0;
  logic [511:0] wdata = '0;
  logic [511:0] rdata;
  logic         done;
  logic         ready;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int n_done;
  logic [511:0] held;

  ddr_responder #(
    .LINE_AW    (10),
    .RD_LATENCY (RD_L),
    .WR_LATENCY (WR_L)
  ) dut (
    .clock              (clock),
    .reset_n            (reset_n),
    .ddr_chip_enable    (ce),
    .ddr_index          (idx),
    .ddr_write_enable   (we),
    .ddr_burst_mode     (burst),
    .ddr_write_mask     (mask),
    .ddr_write_data     (wdata),
    .ddr_read_data      (rdata),
    .ddr_operation_done (done),
    .ddr_ready          (ready)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc++;

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Issue one request from a negedge; returns at the negedge of the cycle after done.
  task automatic do_req(input string tag, input logic w, input logic b, input logic [63:0] a,
                        input logic [511:0] m, input logic [511:0] d);
    int t0;
    int lat;
    int n;
    int exp_l;
    exp_l = w ? WR_L : RD_L;
    n = 0;
    while (!ready && n < 20) begin
      @(negedge clock);
      n++;
    end
    check({tag, "_rdy"}, 512'(ready), 512'(1));
    ce = 1'b1; we = w; burst = b; idx = a; mask = m; wdata = d;
    @(negedge clock);
    t0 = cyc;
    ce = 1'b0;
    n = 0;
    while (!done && n < 40) begin
      @(negedge clock);
      n++;
    end
    lat = cyc - t0 + 1;
`ifdef DDR_RESP_JITTER_EN
    check({tag, "_lat"}, 512'(lat >= exp_l && lat <= exp_l + 3 && done), 512'(1));
`else
    check({tag, "_lat"}, 512'(done ? lat : -1), 512'(exp_l));
`endif
    check({tag, "_rdy_in_done"}, 512'(ready), 512'(0));
    @(negedge clock);
    check({tag, "_done_1cyc"}, 512'(done), 512'(0));
    check({tag, "_rdy_after"}, 512'(ready), 512'(1));
  endtask

  initial begin
    repeat (3) begin
      @(negedge clock);
      check("rst_ready", 512'(ready), 512'(0));
      check("rst_done", 512'(done), 512'(0));
      check("rst_rdata", rdata, '0);
    end
    reset_n = 1'b1;
    #1 check("rel_ready_pre_edge", 512'(ready), 512'(0));
    @(negedge clock);
    check("rel_ready", 512'(ready), 512'(1));
    check("rel_rdata", rdata, '0);

    do_req("bw", 1'b1, 1'b1, 64'h40, ONES, {8{W0}});
    do_req("br", 1'b0, 1'b1, 64'h40, '0, '0);
    check("br_data", rdata, {8{W0}});

    held = rdata;
    do_req("ww", 1'b1, 1'b0, 64'h48, {{448{1'b1}}, 64'h0000_0000_FFFF_FFFF},
           {{448{1'b1}}, 64'h1111_2222_3333_4444});
    check("ww_rdata_held", rdata, held);
    do_req("wr", 1'b0, 1'b0, 64'h48, '0, '0);
    check("wr_data", rdata, {448'b0, 64'hDEAD_BEEF_3333_4444});
    do_req("wr7", 1'b0, 1'b0, 64'h78, '0, '0);
    check("wr7_data", rdata, {448'b0, W0});
    do_req("wbr", 1'b0, 1'b1, 64'h40, '0, '0);
    check("wbr_data", rdata, {W0, W0, W0, W0, W0, W0, 64'hDEAD_BEEF_3333_4444, W0});

    do_req("pre80", 1'b1, 1'b1, 64'h80, ONES, {8{64'hC0C0_C0C0_0000_0002}});
    ce = 1'b1; we = 1'b1; burst = 1'b1; idx = 64'h100; mask = ONES; wdata = {8{64'hAAAA_0000_0000_0004}};
    @(negedge clock);
    idx = 64'h80; wdata = {8{64'hBBBB_0000_0000_0003}};
    n_done = 0;
    for (int i = 0; i < 8; i++) begin
      if (done) begin
        n_done++;
        ce = 1'b0;
      end
      @(negedge clock);
    end
    ce = 1'b0;
    check("busy_done_count", 512'(n_done), 512'(1));
    do_req("busy_r100", 1'b0, 1'b1, 64'h100, '0, '0);
    check("busy_r100_data", rdata, {8{64'hAAAA_0000_0000_0004}});
    do_req("busy_r80", 1'b0, 1'b1, 64'h80, '0, '0);
    check("busy_r80_data", rdata, {8{64'hC0C0_C0C0_0000_0002}});

    do_req("preC0", 1'b1, 1'b1, 64'hC0, ONES, {8{64'h0123_4567_89AB_CDEF}});
    ce = 1'b1; we = 1'b1; burst = 1'b1; idx = 64'hC0; mask = ONES; wdata = 512'h55;
    @(negedge clock);
    ce = 1'b0;
    reset_n = 1'b0;
    #1;
    check("abort_ready", 512'(ready), 512'(0));
    check("abort_rdata", rdata, '0);
    n_done = 0;
    repeat (2) begin
      @(negedge clock);
      if (done) n_done++;
    end
    reset_n = 1'b1;
    repeat (5) begin
      @(negedge clock);
      if (done) n_done++;
    end
    check("abort_no_done", 512'(n_done), 512'(0));
    do_req("abort_rd", 1'b0, 1'b1, 64'hC0, '0, '0);
    check("abort_rd_data", rdata, {8{64'h0123_4567_89AB_CDEF}});

    do_req("alias_w", 1'b1, 1'b1, (64'h1 << 16) | 64'h40, ONES, {8{64'h7777_8888_9999_0005}});
    do_req("alias_r", 1'b0, 1'b1, 64'h40, '0, '0);
    check("alias_data", rdata, {8{64'h7777_8888_9999_0005}});
    do_req("alias_w63", 1'b1, 1'b1, 64'h8000_0000_0000_0080, ONES, {8{64'h6666_0000_0000_0006}});
    do_req("alias_r63", 1'b0, 1'b1, 64'h80, '0, '0);
    check("alias63_data", rdata, {8{64'h6666_0000_0000_0006}});

`ifdef DDR_RESP_JITTER_EN
    for (int k = 0; k < 1000; k++) begin
      do_req("jit", 1'b0, 1'b1, 64'($urandom_range(0, 1023)) << 6, '0, '0);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

endmodule
